// File: rtl/tc_operand_packer.sv
// Width-converting packer: narrow AXI-Stream beats in, full OUT_W words out.
// A tlast that falls mid-word emits a zero-padded word with per-lane keep bits.
module tc_operand_packer #(
   parameter  int IN_W  = 128,
   parameter  int OUT_W = 512,
   localparam int RATIO = OUT_W / IN_W,
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [IN_W-1:0]    s_axis_tdata,
   input  logic               s_axis_tvalid,
   input  logic               s_axis_tlast,
   output logic               s_axis_tready,
   output logic [OUT_W-1:0]   m_axis_tdata,
   output logic [RATIO-1:0]   m_axis_tkeep,
   output logic               m_axis_tlast,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               busy_o,
   output logic [15:0]        pkt_cnt_o
);

   logic [OUT_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RATIO-1:0] keep_q, keep_d;
   logic [OUT_W-1:0] outData_q, outData_d;
   logic [RATIO-1:0] outKeep_q, outKeep_d;
   logic             outLast_q, outLast_d;
   logic             outValid_q, outValid_d;
   logic [15:0]      pktCnt_q, pktCnt_d;
   logic             busy_q, busy_d;

   logic             ready;
   logic             accept;
   logic             complete;
   logic             outHandshake;
   logic [OUT_W-1:0] mergedData;
   logic [RATIO-1:0] mergedKeep;

   // Ready is held low during reset so the upstream never sees a phantom accept.
   assign ready        = rst_n && en_i && (!outValid_q || m_axis_tready);
   assign accept       = s_axis_tvalid && ready;
   assign complete     = accept && ((idx_q == IDX_W'(RATIO - 1)) || s_axis_tlast);
   assign outHandshake = outValid_q && m_axis_tready;

   // Lanes above idx are still zero in acc, so the merge is already zero-padded.
   always_comb begin
      mergedData = acc_q;
      mergedKeep = keep_q;
      mergedData[int'(idx_q) * IN_W +: IN_W] = s_axis_tdata;
      mergedKeep[idx_q] = 1'b1;
   end

   always_comb begin
      acc_d      = acc_q;
      idx_d      = idx_q;
      keep_d     = keep_q;
      outData_d  = outData_q;
      outKeep_d  = outKeep_q;
      outLast_d  = outLast_q;
      outValid_d = outValid_q;
      pktCnt_d   = pktCnt_q;

      if (outHandshake) begin
         outValid_d = 1'b0;
         if (outLast_q) begin
            pktCnt_d = pktCnt_q + 16'd1;
         end
      end

      if (complete) begin
         outData_d  = mergedData;
         outKeep_d  = mergedKeep;
         outLast_d  = s_axis_tlast;
         outValid_d = 1'b1;
         acc_d      = '0;
         keep_d     = '0;
         idx_d      = '0;
      end else if (accept) begin
         acc_d  = mergedData;
         keep_d = mergedKeep;
         idx_d  = idx_q + IDX_W'(1);
      end

      busy_d = (idx_d != '0) || outValid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         idx_q      <= '0;
         keep_q     <= '0;
         outData_q  <= '0;
         outKeep_q  <= '0;
         outLast_q  <= 1'b0;
         outValid_q <= 1'b0;
         pktCnt_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         keep_q     <= keep_d;
         outData_q  <= outData_d;
         outKeep_q  <= outKeep_d;
         outLast_q  <= outLast_d;
         outValid_q <= outValid_d;
         pktCnt_q   <= pktCnt_d;
         busy_q     <= busy_d;
      end
   end

   assign s_axis_tready = ready;
   assign m_axis_tdata  = outData_q;
   assign m_axis_tkeep  = outKeep_q;
   assign m_axis_tlast  = outLast_q;
   assign m_axis_tvalid = outValid_q;
   assign busy_o        = busy_q;
   assign pkt_cnt_o     = pktCnt_q;

endmodule
